// File: rtl/ctrl_decode_stage.sv
// Registered RV32I control decoder with a valid/ready output stage backed by a 2-entry skid.
// Optional M-extension decode is enabled by defining RV32M_EN.
module ctrl_decode_stage #(
  parameter int ALUOP_W  = 6,
  parameter int REGIDX_W = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         instr_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic                flush_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                I_EN_o,
  output logic                R_EN_o,
  output logic                S_EN_o,
  output logic                SB_EN_o,
  output logic                U_EN_o,
  output logic                UJ_EN_o,
  output logic                RWR_EN_o,
  output logic                BE_o,
  output logic                JALRE_o,
  output logic                UJE_o,
  output logic [ALUOP_W-1:0]  ALUop_o,
  output logic [REGIDX_W-1:0] rd_o,
  output logic [REGIDX_W-1:0] rs1_o,
  output logic [REGIDX_W-1:0] rs2_o,
  output logic                illegal_o
);

  typedef struct packed {
    logic       i_en;
    logic       r_en;
    logic       s_en;
    logic       sb_en;
    logic       u_en;
    logic       uj_en;
    logic       rwr_en;
    logic       be;
    logic       jalre;
    logic       uje;
    logic [5:0] aluop;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } dec_t;

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_legal;
  dec_t       w_dec;

  dec_t       r_out;
  logic       r_out_vld;
  dec_t       r_skid;
  logic       r_skid_vld;

  assign w_opc = instr_i[6:0];
  assign w_f3  = instr_i[14:12];
  assign w_f7  = instr_i[31:25];

  always_comb begin
    w_dec     = '0;
    w_legal   = 1'b1;
    w_dec.rd  = instr_i[11:7];
    w_dec.rs1 = instr_i[19:15];
    w_dec.rs2 = instr_i[24:20];
    case (w_opc)
      7'b0110011: begin
        w_dec.r_en   = 1'b1;
        w_dec.rwr_en = 1'b1;
        w_dec.aluop  = {2'b00, w_f7[5], w_f3};
        case (w_f7)
          7'b0000000: ;
          7'b0100000: if (!(w_f3 == 3'b000 || w_f3 == 3'b101)) w_legal = 1'b0;
`ifdef RV32M_EN
          7'b0000001: w_dec.aluop = {2'b11, 1'b0, w_f3};
`endif
          default:    w_legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        w_dec.i_en   = 1'b1;
        w_dec.rwr_en = 1'b1;
        w_dec.aluop  = {2'b00, (w_f3 == 3'b101) & w_f7[5], w_f3};
        // Shift-immediates reuse func7 as an encoding field; anything else is reserved.
        if (w_f3 == 3'b001 && w_f7 != 7'b0000000) w_legal = 1'b0;
        if (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000) w_legal = 1'b0;
      end
      7'b0000011: begin
        w_dec.i_en   = 1'b1;
        w_dec.rwr_en = 1'b1;
        w_dec.aluop  = {2'b10, 1'b0, w_f3};
      end
      7'b1100111: begin
        w_dec.i_en   = 1'b1;
        w_dec.rwr_en = 1'b1;
        w_dec.jalre  = 1'b1;
      end
      7'b0100011: begin
        w_dec.s_en  = 1'b1;
        w_dec.aluop = {2'b10, 1'b0, w_f3};
      end
      7'b1100011: begin
        w_dec.sb_en = 1'b1;
        w_dec.be    = 1'b1;
        w_dec.aluop = {2'b01, 1'b0, w_f3};
      end
      7'b0110111, 7'b0010111: begin
        w_dec.u_en   = 1'b1;
        w_dec.rwr_en = 1'b1;
      end
      7'b1101111: begin
        w_dec.uj_en  = 1'b1;
        w_dec.rwr_en = 1'b1;
        w_dec.uje    = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
    if (instr_i[1:0] != 2'b11) w_legal = 1'b0;
    if (!w_legal) begin
      w_dec        = '0;
      w_dec.rd     = instr_i[11:7];
      w_dec.rs1    = instr_i[19:15];
      w_dec.rs2    = instr_i[24:20];
      w_dec.illegal = 1'b1;
    end
  end

  // Skid full implies output regs full, so ready_o alone blocks the third beat.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_out      <= '0;
      r_out_vld  <= 1'b0;
      r_skid     <= '0;
      r_skid_vld <= 1'b0;
    end else if (!r_out_vld || ready_i) begin
      if (r_skid_vld) begin
        r_out      <= r_skid;
        r_out_vld  <= 1'b1;
        r_skid_vld <= 1'b0;
      end else if (valid_i) begin
        r_out     <= w_dec;
        r_out_vld <= 1'b1;
      end else begin
        r_out_vld <= 1'b0;
      end
    end else if (valid_i && !r_skid_vld) begin
      r_skid     <= w_dec;
      r_skid_vld <= 1'b1;
    end
  end

  assign ready_o   = ~r_skid_vld;
  assign valid_o   = r_out_vld;
  assign I_EN_o    = r_out.i_en;
  assign R_EN_o    = r_out.r_en;
  assign S_EN_o    = r_out.s_en;
  assign SB_EN_o   = r_out.sb_en;
  assign U_EN_o    = r_out.u_en;
  assign UJ_EN_o   = r_out.uj_en;
  assign RWR_EN_o  = r_out.rwr_en;
  assign BE_o      = r_out.be;
  assign JALRE_o   = r_out.jalre;
  assign UJE_o     = r_out.uje;
  assign ALUop_o   = ALUOP_W'(r_out.aluop);
  assign rd_o      = REGIDX_W'(r_out.rd);
  assign rs1_o     = REGIDX_W'(r_out.rs1);
  assign rs2_o     = REGIDX_W'(r_out.rs2);
  assign illegal_o = r_out.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Randomised bench for ctrl_decode_stage: queue-based occupancy model plus an opcode-table decoder.
module tb_ctrl_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_i;
  logic [31:0] instr_i;
  logic        ready_o, valid_o;
  logic        I_EN_o, R_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o, RWR_EN_o, BE_o, JALRE_o, UJE_o;
  logic [5:0]  ALUop_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic        illegal_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q[$];
  logic [31:0] last_out;

  ctrl_decode_stage #(.ALUOP_W(6), .REGIDX_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .valid_i(valid_i), .ready_o(ready_o),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .I_EN_o(I_EN_o), .R_EN_o(R_EN_o), .S_EN_o(S_EN_o), .SB_EN_o(SB_EN_o), .U_EN_o(U_EN_o),
    .UJ_EN_o(UJ_EN_o), .RWR_EN_o(RWR_EN_o), .BE_o(BE_o), .JALRE_o(JALRE_o), .UJE_o(UJE_o),
    .ALUop_o(ALUop_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  wire [31:0] obs = {I_EN_o, R_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o, RWR_EN_o, BE_o, JALRE_o,
                     UJE_o, ALUop_o, rd_o, rs1_o, rs2_o, illegal_o};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Enable order: I R S SB U UJ RWR BE JALRE UJE
  function automatic logic [31:0] ref_dec(input logic [31:0] ins);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         legal;
    logic [9:0] en;
    int         aop;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    legal = 1; en = '0; aop = 0;
    case (opc)
      7'h33: begin
        en = 10'b0100001000;
        if (f7 == 7'h00) aop = int'(f3);
        else if (f7 == 7'h20) begin
          aop = 8 + int'(f3);
          if (!(f3 == 3'd0 || f3 == 3'd5)) legal = 0;
        end
`ifdef RV32M_EN
        else if (f7 == 7'h01) aop = 48 + int'(f3);
`endif
        else legal = 0;
      end
      7'h13: begin
        en = 10'b1000001000;
        aop = int'(f3);
        if (f3 == 3'd1 && f7 != 7'h00) legal = 0;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) aop = aop + 8;
          else if (f7 != 7'h00) legal = 0;
        end
      end
      7'h03: begin en = 10'b1000001000; aop = 32 + int'(f3); end
      7'h67: en = 10'b1000001010;
      7'h23: begin en = 10'b0010000000; aop = 32 + int'(f3); end
      7'h63: begin en = 10'b0001000100; aop = 16 + int'(f3); end
      7'h37, 7'h17: en = 10'b0000101000;
      7'h6F: en = 10'b0000011001;
      default: legal = 0;
    endcase
    if (ins[1:0] != 2'b11) legal = 0;
    if (!legal) begin en = '0; aop = 0; end
    return {en, 6'(aop), ins[11:7], ins[19:15], ins[24:20], logic'(!legal)};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs[9];
    logic [6:0] opc;
    logic [6:0] f7;
    logic [31:0] body;
    int k;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    k = $urandom_range(0, 10);
    opc = (k < 9) ? opcs[k] : 7'($urandom);
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    body = $urandom;
    return {f7, body[24:7], opc};
  endfunction

  // Drive one cycle of inputs, check the model at negedge, then advance to just past posedge.
  task automatic step(input logic v, input logic [31:0] ins, input logic rdy,
                      input logic fl, input logic rs);
    int cnt;
    valid_i = v; instr_i = ins; ready_i = rdy; flush_i = fl; rst_i = rs;
    @(negedge clk_i);
    cnt = q.size();
    chk("valid_o", 32'(valid_o), 32'(cnt > 0));
    chk("ready_o", 32'(ready_o), 32'(cnt < 2));
    chk("outputs", obs, (cnt > 0) ? q[0] : last_out);
    if (rs || fl) begin
      q.delete();
      last_out = '0;
    end else begin
      if (cnt > 0 && rdy) last_out = q.pop_front();
      if (v && cnt < 2) q.push_back(ref_dec(ins));
    end
    @(posedge clk_i);
    #1;
  endtask

  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] SUB  = 32'h402081B3;
  localparam logic [31:0] SRAI = 32'h4050D093;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] MUL4 = 32'h0220C1B3;

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; instr_i = '0;
    q.delete();
    last_out = '0;
    repeat (2) @(posedge clk_i);
    #1;
    step(0, 0, 1, 0, 0);

    step(1, ADD, 1, 0, 0);
    chk("add_vld", 32'(valid_o), 1);
    chk("add_ren", 32'({R_EN_o, RWR_EN_o}), 3);
    chk("add_aluop", 32'(ALUop_o), 32'h00);
    chk("add_rd", 32'(rd_o), 3);
    step(1, SUB, 1, 0, 0);
    chk("sub_aluop", 32'(ALUop_o), 32'h08);
    step(1, SRAI, 1, 0, 0);
    chk("srai_ien", 32'(I_EN_o), 1);
    chk("srai_aluop", 32'(ALUop_o), 32'h0D);
    step(1, BEQ, 1, 0, 0);
    chk("beq_en", 32'({SB_EN_o, BE_o}), 3);
    chk("beq_aluop", 32'(ALUop_o), 32'h10);
    step(0, 0, 1, 0, 0);

    // Stall with three offered beats, then drain in order.
    step(1, ADD, 0, 0, 0);
    step(1, SUB, 0, 0, 0);
    chk("stall_rdy", 32'(ready_o), 0);
    step(1, BEQ, 0, 0, 0);
    step(1, BEQ, 1, 0, 0);
    step(1, BEQ, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // Flush with skid full and a beat offered.
    step(1, ADD, 0, 0, 0);
    step(1, SUB, 0, 0, 0);
    step(1, SRAI, 1, 1, 0);
    chk("flush_vld", 32'(valid_o), 0);
    chk("flush_rdy", 32'(ready_o), 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    step(1, 32'hFFFFFFFF, 1, 0, 0);
    chk("ill_ff", 32'({valid_o, illegal_o, R_EN_o, I_EN_o, RWR_EN_o}), 32'b11000);
    step(1, MUL4, 1, 0, 0);
`ifdef RV32M_EN
    chk("mul_ill", 32'(illegal_o), 0);
    chk("mul_aluop", 32'(ALUop_o), 32'h34);
`else
    chk("mul_ill", 32'({valid_o, illegal_o, R_EN_o, RWR_EN_o}), 32'b1100);
    chk("mul_aluop", 32'(ALUop_o), 0);
`endif
    step(0, 0, 1, 0, 0);

    // Reset in the middle of a stall.
    step(1, ADD, 0, 0, 0);
    step(1, SUB, 0, 0, 0);
    step(1, BEQ, 0, 0, 1);
    chk("rst_out", obs, 0);
    chk("rst_rdy", 32'({valid_o, ready_o}), 1);

    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 3) != 0), rand_instr(),
           logic'($urandom_range(0, 2) != 0),
           logic'($urandom_range(0, 39) == 0),
           logic'($urandom_range(0, 299) == 0));
    end
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
